// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for the E stage (DIV/DIVU).
// Quotient goes to LO, remainder to HI; div_ready holds the hazard unit until the result exists.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_en,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             stall_e,
    input  logic             flush_e,
    output logic             div_ready,
    output logic             div_busy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_q_neg;
    logic             r_r_neg;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_div_ext;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    // -2^(W-1) negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        w_a_mag = (div_signed && src_a[WIDTH-1]) ? -src_a : src_a;
        w_b_mag = (div_signed && src_b[WIDTH-1]) ? -src_b : src_b;
    end

    // One restoring step: r_quo shifts dividend bits out the top and quotient bits in at the bottom.
    always_comb begin
        w_shift    = {r_rem, r_quo[WIDTH-1]};
        w_div_ext  = {1'b0, r_div};
        w_diff     = w_shift - w_div_ext;
        w_ge       = (w_shift >= w_div_ext);
        w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_quo_next = {r_quo[WIDTH-2:0], w_ge};
    end

    // Handshake: div_ready is high exactly while a finished result for the current E
    // instruction is held; the instruction consumes it on the first edge with !stall_e.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (flush_e) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (div_en) begin
                        r_rem   <= '0;
                        r_quo   <= w_a_mag;
                        r_div   <= w_b_mag;
                        r_q_neg <= div_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        r_r_neg <= div_signed && src_a[WIDTH-1];
                        r_count <= CW'(WIDTH - 1);
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Losing div_en mid-divide means the instruction vanished; abandon it.
                    if (!div_en) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem   <= w_rem_next;
                        r_quo   <= w_quo_next;
                        r_count <= r_count - CW'(1);
                        if (r_count == '0) begin
                            r_quotient  <= r_q_neg ? -w_quo_next : w_quo_next;
                            r_remainder <= r_r_neg ? -w_rem_next : w_rem_next;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!stall_e) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign div_ready = (r_state == S_DONE);
    assign div_busy  = (r_state == S_BUSY);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign dbg_state = r_state;

endmodule
